simon_arbiter: RTL and testbench
================================

SIMON_ARBITER -- requirements
Module: simon_arbiter

Interface
REQ-001 Parameters SHALL be listed one per line as name, default, meaning.
- LATENCY, 32: fixed simon_pipeline latency in cycles, from pipe_start sampled to pipe_ciphertext valid.
- FIFO_DEPTH, 4: per-requester result FIFO depth, which is also the credit limit.

REQ-002 Ports SHALL be listed one per line as name, direction, width, meaning (N = 0,1).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- reqN_valid  in  1  requester N has a job.
- reqN_ready  out  1  job from requester N accepted this cycle when valid.
- reqN_plaintext  in  32  job plaintext.
- reqN_keytext  in  64  job key.
- rspN_valid  out  1  result available for requester N.
- rspN_ready  in  1  requester N consumes the result.
- rspN_ciphertext  out  32  result data.
- pipe_start  out  1  issue strobe to simon_pipeline.
- pipe_plaintext  out  32  issued plaintext.
- pipe_keytext  out  64  issued key.
- pipe_ciphertext  in  32  simon_pipeline output.
- busy  out  1  any job in flight or any FIFO non-empty.

REQ-003 The block SHALL use only clk; rst SHALL be synchronous and active-high.

Function
REQ-004 credit_N SHALL equal FIFO_DEPTH - (inflight_N + fifo_count_N); eligible_N SHALL equal credit_N > 0.
REQ-005 Arbitration SHALL be round-robin with a 1-bit priority pointer prio.
- reqN_ready = eligible_N && !(reqM_valid && eligible_M && prio==M), where M is the other requester.
- reqN_ready SHALL NOT depend on reqN_valid.
REQ-006 At most one transfer SHALL occur per cycle; a transfer is reqN_valid && reqN_ready.
REQ-007 prio SHALL move to the other requester after any cycle in which both requesters are valid and eligible; otherwise prio SHALL hold.
REQ-008 Issue SHALL be registered: a transfer at cycle a gives pipe_start=1 at a+1, with that job's plaintext and key on pipe_plaintext and pipe_keytext.
REQ-009 When pipe_start=0, pipe_plaintext and pipe_keytext SHALL hold their last values.
REQ-010 A tag shift register (valid bit plus requester id, LATENCY stages) SHALL track each issue.
- pipe_ciphertext SHALL be captured at cycle a+1+LATENCY into FIFO N of the tagged requester.
REQ-011 Each FIFO SHALL be registered storage with head-of-queue output.
- rspN_valid = FIFO N non-empty; rspN_ciphertext = head entry.
- Pop on rspN_valid && rspN_ready.
REQ-012 Minimum accept-to-rspN_valid latency SHALL be LATENCY+2 cycles.
REQ-013 Results SHALL be returned in acceptance order per requester; results SHALL never be routed to the wrong requester.
REQ-014 Simultaneous push and pop on one FIFO SHALL be legal; occupancy SHALL be unchanged and data order preserved.
REQ-015 Credit accounting SHALL guarantee no FIFO overflow.
- inflight_N increments on transfer and decrements on capture.
- A credit freed by a pop SHALL be usable from the next cycle.
REQ-016 If a requester holds rspN_ready=0, that requester SHALL stall after FIFO_DEPTH outstanding jobs; the other requester SHALL be unaffected.
REQ-017 rspN_ciphertext SHALL be stable while rspN_valid=1 and rspN_ready=0.
REQ-018 busy SHALL be 1 whenever any tag is valid or any FIFO is non-empty.

Reset
REQ-019 While rst=1, the outputs SHALL be:
- reqN_ready=0, rspN_valid=0, pipe_start=0, busy=0.
- pipe_plaintext=0, pipe_keytext=0, rspN_ciphertext=0.
REQ-020 Reset SHALL clear the tags, FIFOs, inflight counters and prio (prio=0).
REQ-021 Jobs in flight at reset SHALL be discarded; pipe_ciphertext arriving after reset SHALL be ignored.
REQ-022 The first transfer SHALL be possible in the cycle after rst deasserts.

Verification
REQ-023 Single job on a reference model of simon_pipeline:
- Stimulus: req0 key 0x1918111009080100, pt 0x65656877, rsp0_ready=1.
- Response: rsp0_ciphertext=0xc69be9bb exactly LATENCY+2 cycles after accept; busy=0 afterwards.
REQ-024 Both requesters valid every cycle, rsp always ready:
- Response: grants alternate 0,1,0,1 starting with req0; pipe_start=1 every cycle; no lost or misrouted result.
REQ-025 Backpressure, rsp0_ready=0, 10 jobs offered on req0:
- Response: exactly FIFO_DEPTH accepted; req0_ready=0 thereafter; req1 traffic continues at full rate.
- Releasing rsp0_ready yields the results in acceptance order.
REQ-026 FIFO at full with simultaneous capture and pop:
- Response: occupancy stays constant; no overflow; data order intact.
REQ-027 rst asserted for 1 cycle with 5 jobs in flight:
- Response: all outputs at reset values; late pipe_ciphertext is not delivered; a new job completes correctly.

Source files
------------

// File: rtl/simon_arbiter.sv
// Two-requester round-robin front end for a fixed-latency simon_pipeline.
// Credits bound each requester's in-flight jobs plus queued results to its result FIFO depth.
module simon_arbiter #(
    parameter int unsigned LATENCY    = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_plaintext,
    input  logic [63:0] req0_keytext,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_plaintext,
    input  logic [63:0] req1_keytext,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_ciphertext,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_ciphertext,
    output logic        pipe_start,
    output logic [31:0] pipe_plaintext,
    output logic [63:0] pipe_keytext,
    input  logic [31:0] pipe_ciphertext,
    output logic        busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [1:0] valid, ready, xfer, elig, push, pop, rsp_rdy;

    logic [CW-1:0]      inflight_q [2];
    logic [CW-1:0]      count_q    [2];
    logic [PW-1:0]      rptr_q     [2];
    logic [PW-1:0]      wptr_q     [2];
    logic [31:0]        mem_q      [2][FIFO_DEPTH];
    logic               prio_q;
    logic               start_q;
    logic               start_id_q;
    logic [31:0]        pt_q;
    logic [63:0]        key_q;
    logic [LATENCY-1:0] tag_v_q;
    logic [LATENCY-1:0] tag_id_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid   = {req1_valid, req0_valid};
    assign rsp_rdy = {rsp1_ready, rsp0_ready};

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            elig[n] = (inflight_q[n] + count_q[n]) < CW'(FIFO_DEPTH);
            pop[n]  = (count_q[n] != '0) && rsp_rdy[n];
        end
        // The pointer only takes a grant away when the other side could actually use it.
        ready[0] = !rst && elig[0] && !(valid[1] && elig[1] && prio_q);
        ready[1] = !rst && elig[1] && !(valid[0] && elig[0] && !prio_q);
        xfer     = valid & ready;
        push[0]  = tag_v_q[LATENCY-1] && !tag_id_q[LATENCY-1];
        push[1]  = tag_v_q[LATENCY-1] && tag_id_q[LATENCY-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q     <= 1'b0;
            start_q    <= 1'b0;
            start_id_q <= 1'b0;
            pt_q       <= '0;
            key_q      <= '0;
            tag_v_q    <= '0;
            tag_id_q   <= '0;
            for (int n = 0; n < 2; n++) begin
                inflight_q[n] <= '0;
                count_q[n]    <= '0;
                rptr_q[n]     <= '0;
                wptr_q[n]     <= '0;
                for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                    mem_q[n][i] <= '0;
                end
            end
        end else begin
            if (valid[0] && elig[0] && valid[1] && elig[1]) begin
                prio_q <= !prio_q;
            end
            start_q <= |xfer;
            if (|xfer) begin
                start_id_q <= xfer[1];
                pt_q       <= xfer[1] ? req1_plaintext : req0_plaintext;
                key_q      <= xfer[1] ? req1_keytext : req0_keytext;
            end
            // Tag stage LATENCY-1 lines up with the cycle the pipeline result is valid.
            tag_v_q[0]  <= start_q;
            tag_id_q[0] <= start_id_q;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
            for (int n = 0; n < 2; n++) begin
                inflight_q[n] <= inflight_q[n] + CW'(xfer[n]) - CW'(push[n]);
                count_q[n]    <= count_q[n] + CW'(push[n]) - CW'(pop[n]);
                if (push[n]) begin
                    mem_q[n][wptr_q[n]] <= pipe_ciphertext;
                    wptr_q[n]           <= ptr_inc(wptr_q[n]);
                end
                if (pop[n]) begin
                    rptr_q[n] <= ptr_inc(rptr_q[n]);
                end
            end
        end
    end

    assign req0_ready      = ready[0];
    assign req1_ready      = ready[1];
    assign rsp0_valid      = !rst && (count_q[0] != '0);
    assign rsp1_valid      = !rst && (count_q[1] != '0);
    assign rsp0_ciphertext = rst ? '0 : mem_q[0][rptr_q[0]];
    assign rsp1_ciphertext = rst ? '0 : mem_q[1][rptr_q[1]];
    assign pipe_start      = !rst && start_q;
    assign pipe_plaintext  = rst ? '0 : pt_q;
    assign pipe_keytext    = rst ? '0 : key_q;
    assign busy            = !rst && ((inflight_q[0] != '0) || (inflight_q[1] != '0) ||
                                      (count_q[0] != '0) || (count_q[1] != '0));

endmodule

// File: tb/tb_simon_arbiter.sv
// Scoreboard bench for simon_arbiter with a behavioural Simon32/64 pipeline model.
module tb_simon_arbiter;

    localparam int unsigned LAT = 5;
    localparam int unsigned DEP = 8;

    logic        clk, rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_plaintext, req1_plaintext;
    logic [63:0] req0_keytext, req1_keytext;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_ciphertext, rsp1_ciphertext;
    logic        pipe_start;
    logic [31:0] pipe_plaintext, pipe_ciphertext;
    logic [63:0] pipe_keytext;
    logic        busy;

    simon_arbiter #(.LATENCY(LAT), .FIFO_DEPTH(DEP)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_plaintext(req0_plaintext), .req0_keytext(req0_keytext),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_plaintext(req1_plaintext), .req1_keytext(req1_keytext),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_ciphertext(rsp0_ciphertext),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_ciphertext(rsp1_ciphertext),
        .pipe_start(pipe_start), .pipe_plaintext(pipe_plaintext),
        .pipe_keytext(pipe_keytext), .pipe_ciphertext(pipe_ciphertext),
        .busy(busy)
    );

    typedef struct {
        logic [31:0] ct;
        int          acc;
    } entry_t;

    entry_t      sb0[$];
    entry_t      sb1[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_cnt[2] = '{0, 0};
    int          outst[2] = '{0, 0};
    logic        mprio = 1'b0;
    logic        exp_start = 1'b0;
    logic [31:0] exp_pt = '0;
    logic [63:0] exp_key = '0;
    logic        prev_hold[2] = '{1'b0, 1'b0};
    logic [31:0] prev_ct[2];
    bit          exact_lat = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rol(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [15:0] ror(input logic [15:0] v, input int s);
        return (v >> s) | (v << (16 - s));
    endfunction

    function automatic logic [31:0] simon(input logic [31:0] pt, input logic [63:0] key);
        logic [15:0] k[32];
        logic [15:0] x, y, t;
        logic [61:0] z;
        z = 62'b01100111000011010100100010111110110011100001101010010001011111;
        k[0] = key[15:0];
        k[1] = key[31:16];
        k[2] = key[47:32];
        k[3] = key[63:48];
        for (int i = 4; i < 32; i++) begin
            t    = ror(k[i-1], 3) ^ k[i-3];
            t    = t ^ ror(t, 1);
            k[i] = ~k[i-4] ^ t ^ {15'd0, z[i-4]} ^ 16'd3;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pipeline model: result of the job issued in cycle c appears during cycle c+LAT.
    initial begin
        logic [32:0] dl[$];
        logic [32:0] e;
        pipe_ciphertext = '0;
        forever begin
            @(negedge clk);
            dl.push_back({pipe_start, simon(pipe_plaintext, pipe_keytext)});
            if (dl.size() > LAT) begin
                e = dl.pop_front();
                pipe_ciphertext = e[32] ? e[31:0] : $urandom;
            end
        end
    end

    // Monitor / scoreboard: samples mid-cycle, checks outputs, then advances the model.
    initial begin
        logic        v[2], r[2], rv[2], rr[2], el[2], er[2];
        logic [31:0] ct[2], pt[2];
        logic [63:0] key[2];
        entry_t      e;
        bit          have;
        bit          any_x;
        int          lat;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_req0_ready", req0_ready, 0);
                chk("rst_req1_ready", req1_ready, 0);
                chk("rst_rsp0_valid", rsp0_valid, 0);
                chk("rst_rsp1_valid", rsp1_valid, 0);
                chk("rst_pipe_start", pipe_start, 0);
                chk("rst_busy", busy, 0);
                chk("rst_pipe_pt", pipe_plaintext, 0);
                chk("rst_pipe_key", pipe_keytext, 0);
                chk("rst_rsp0_ct", rsp0_ciphertext, 0);
                chk("rst_rsp1_ct", rsp1_ciphertext, 0);
                sb0.delete();
                sb1.delete();
                outst     = '{0, 0};
                mprio     = 1'b0;
                exp_start = 1'b0;
                exp_pt    = '0;
                exp_key   = '0;
                prev_hold = '{1'b0, 1'b0};
            end else begin
                v   = '{req0_valid, req1_valid};
                r   = '{req0_ready, req1_ready};
                rv  = '{rsp0_valid, rsp1_valid};
                rr  = '{rsp0_ready, rsp1_ready};
                ct  = '{rsp0_ciphertext, rsp1_ciphertext};
                pt  = '{req0_plaintext, req1_plaintext};
                key = '{req0_keytext, req1_keytext};
                for (int n = 0; n < 2; n++) begin
                    if (prev_hold[n]) begin
                        chk($sformatf("rsp%0d_hold_valid", n), rv[n], 1);
                        chk($sformatf("rsp%0d_hold_data", n), ct[n], prev_ct[n]);
                    end
                    el[n] = outst[n] < int'(DEP);
                end
                er[0] = el[0] && !(v[1] && el[1] && mprio);
                er[1] = el[1] && !(v[0] && el[0] && !mprio);
                chk("req0_ready", r[0], er[0]);
                chk("req1_ready", r[1], er[1]);
                chk("pipe_start", pipe_start, exp_start);
                chk("pipe_plaintext", pipe_plaintext, exp_pt);
                chk("pipe_keytext", pipe_keytext, exp_key);
                chk("busy", busy, (outst[0] + outst[1]) > 0);
                for (int n = 0; n < 2; n++) begin
                    if (rv[n] && rr[n]) begin
                        have = (n == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
                        chk($sformatf("rsp%0d_expected", n), have, 1);
                        if (have) begin
                            e   = (n == 0) ? sb0.pop_front() : sb1.pop_front();
                            lat = cyc - e.acc;
                            chk($sformatf("rsp%0d_ct", n), ct[n], e.ct);
                            if (exact_lat) chk("latency_exact", 64'(lat), 64'(LAT + 2));
                            else           chk("latency_min", lat >= int'(LAT + 2), 1);
                        end
                        outst[n]--;
                    end
                end
                any_x = 1'b0;
                for (int n = 0; n < 2; n++) begin
                    if (v[n] && r[n]) begin
                        e.ct  = simon(pt[n], key[n]);
                        e.acc = cyc;
                        if (n == 0) sb0.push_back(e);
                        else        sb1.push_back(e);
                        outst[n]++;
                        acc_cnt[n]++;
                        any_x   = 1'b1;
                        exp_pt  = pt[n];
                        exp_key = key[n];
                    end
                end
                chk("one_transfer", (v[0] && r[0]) && (v[1] && r[1]), 0);
                if (v[0] && el[0] && v[1] && el[1]) mprio = !mprio;
                exp_start = any_x;
                for (int n = 0; n < 2; n++) begin
                    prev_hold[n] = rv[n] && !rr[n];
                    prev_ct[n]   = ct[n];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        req0_plaintext = $urandom;
        req0_keytext   = {$urandom, $urandom};
        req1_plaintext = $urandom;
        req1_keytext   = {$urandom, $urandom};
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (sb0.size() + sb1.size()) > 0; i++) tick();
        chk("drain_empty", 64'(sb0.size() + sb1.size()), 0);
    endtask

    initial begin
        int a0, a1, a;
        bit got;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        rand_data();
        repeat (3) @(posedge clk);
        #1;

        // Known-answer job, exact latency, first transfer right after reset.
        rst = 1'b0;
        rsp0_ready = 1; rsp1_ready = 1;
        exact_lat = 1'b1;
        req0_valid = 1;
        req0_plaintext = 32'h65656877;
        req0_keytext = 64'h1918111009080100;
        tick();
        req0_valid = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rsp0_valid) begin
                got = 1'b1;
                chk("kat_ct", rsp0_ciphertext, 32'hc69be9bb);
            end
        end
        chk("kat_seen", got, 1);
        tick();
        tick();
        @(negedge clk);
        chk("kat_busy_after", busy, 0);
        tick();
        exact_lat = 1'b0;

        // Both requesters saturating: strict alternation and a start every cycle.
        a0 = acc_cnt[0]; a1 = acc_cnt[1];
        for (int i = 0; i < 40; i++) begin
            rand_data();
            req0_valid = 1; req1_valid = 1;
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        chk("alt_acc0", 64'(acc_cnt[0] - a0), 20);
        chk("alt_acc1", 64'(acc_cnt[1] - a1), 20);
        drain();

        // Requester 0 backpressured: it stalls at DEP jobs, requester 1 keeps full rate.
        rsp0_ready = 0; rsp1_ready = 1;
        a0 = acc_cnt[0]; a1 = acc_cnt[1];
        for (int i = 0; i < 60; i++) begin
            rand_data();
            if (i == 20) a1 = acc_cnt[1];
            req0_valid = (acc_cnt[0] - a0) < 10;
            req1_valid = 1;
            tick();
        end
        chk("bp_acc0", 64'(acc_cnt[0] - a0), DEP);
        chk("bp_acc1_full_rate", 64'(acc_cnt[1] - a1), 40);
        req0_valid = 0; req1_valid = 0;
        rsp0_ready = 1;
        drain();

        // Fill FIFO 0, then stream with concurrent capture and pop near full.
        rsp0_ready = 0;
        for (int i = 0; i < 20; i++) begin
            rand_data();
            req0_valid = 1;
            tick();
        end
        for (int i = 0; i < 60; i++) begin
            rand_data();
            rsp0_ready = (i < 30) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
        end
        req0_valid = 0;
        rsp0_ready = 1;
        drain();

        // Random traffic with random response backpressure.
        for (int i = 0; i < 400; i++) begin
            rand_data();
            req0_valid = $urandom_range(0, 3) != 0;
            req1_valid = $urandom_range(0, 3) != 0;
            rsp0_ready = $urandom_range(0, 3) != 0;
            rsp1_ready = $urandom_range(0, 2) != 0;
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        drain();

        // Reset with five jobs in flight; their late results must vanish.
        a = acc_cnt[0] + acc_cnt[1];
        for (int i = 0; i < 20 && (acc_cnt[0] + acc_cnt[1] - a) < 5; i++) begin
            rand_data();
            req0_valid = 1; req1_valid = 1;
            tick();
        end
        chk("rst_inflight_jobs", 64'(acc_cnt[0] + acc_cnt[1] - a), 5);
        req0_valid = 0; req1_valid = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        chk("post_rst_rsp0", rsp0_valid, 0);
        chk("post_rst_rsp1", rsp1_valid, 0);
        tick();
        rand_data();
        req1_valid = 1;
        tick();
        req1_valid = 0;
        drain();
        chk("post_rst_job", 64'(acc_cnt[0] + acc_cnt[1] - a), 6);
        tick();
        tick();
        @(negedge clk);
        chk("final_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
